// File: rtl/regmodel0_regmodel_core_reg_intf_reqseq.sv
// Request sequencer: accepts one register request, drives a single req/ack access with
// timeout into the register bank, and returns read data plus an error code.
module regmodel0_regmodel_core_reg_intf_reqseq #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    input  logic [59:0] req_payload_i,
    output logic        req_ready_o,
    output logic        reg_req_o,
    output logic        reg_wr_o,
    output logic [20:0] reg_addr_o,
    output logic [3:0]  reg_be_o,
    output logic [31:0] reg_wdata_o,
    input  logic        reg_ack_i,
    input  logic [31:0] reg_rdata_i,
    input  logic        reg_err_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic [1:0]  rsp_err_o,
    output logic        rsp_wr_o,
    input  logic        rsp_ready_i
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [3:0]  be_q, be_d;
    logic [20:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  err_q, err_d;

    logic        in_wr_s;
    logic        dec_err_s;

    assign in_wr_s   = req_payload_i[59];
    assign dec_err_s = (req_payload_i[33:32] != 2'b00) || (in_wr_s && (req_payload_i[58:55] == 4'h0));

    // Next-state and captured request/response fields
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    wr_d    = in_wr_s;
                    be_d    = in_wr_s ? req_payload_i[58:55] : 4'hF;
                    addr_d  = req_payload_i[54:34];
                    wdata_d = in_wr_s ? req_payload_i[31:0] : 32'h0;
                    rdata_d = 32'h0;
                    cnt_d   = 8'd0;
                    if (dec_err_s) begin
                        err_d   = 2'b11;
                        state_d = S_RESP;
                    end else begin
                        err_d   = 2'b00;
                        state_d = S_ACCESS;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCESS: begin
                cnt_d = cnt_q + 8'd1;
                // An ack in the final counted cycle still wins over the timeout
                if (reg_ack_i) begin
                    err_d   = reg_err_i ? 2'b01 : 2'b00;
                    rdata_d = (!wr_q && !reg_err_i) ? reg_rdata_i : 32'h0;
                    state_d = S_RESP;
                end else if (cnt_q == TO_LAST) begin
                    err_d   = 2'b10;
                    rdata_d = 32'h0;
                    state_d = S_RESP;
                end else begin
                    state_d = S_ACCESS;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and field registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            wr_q    <= 1'b0;
            be_q    <= 4'h0;
            addr_q  <= 21'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Ready is masked by rst so it reads 0 for the whole reset window
    assign req_ready_o = (state_q == S_IDLE) && !rst;

    assign reg_req_o   = (state_q == S_ACCESS);
    assign reg_wr_o    = reg_req_o ? wr_q    : 1'b0;
    assign reg_addr_o  = reg_req_o ? addr_q  : 21'h0;
    assign reg_be_o    = reg_req_o ? be_q    : 4'h0;
    assign reg_wdata_o = reg_req_o ? wdata_q : 32'h0;

    assign rsp_valid_o = (state_q == S_RESP);
    assign rsp_rdata_o = rsp_valid_o ? rdata_q : 32'h0;
    assign rsp_err_o   = rsp_valid_o ? err_q   : 2'b00;
    assign rsp_wr_o    = rsp_valid_o ? wr_q    : 1'b0;

endmodule

// File: tb/tb_regmodel0_regmodel_core_reg_intf_reqseq.sv
// Directed bench for the register request sequencer: a transaction-level model is
// compared against every output each cycle, plus hand-computed literal checks.
module tb_regmodel0_regmodel_core_reg_intf_reqseq;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic [59:0] req_payload_i;
    logic        req_ready_o;
    logic        reg_req_o;
    logic        reg_wr_o;
    logic [20:0] reg_addr_o;
    logic [3:0]  reg_be_o;
    logic [31:0] reg_wdata_o;
    logic        reg_ack_i;
    logic [31:0] reg_rdata_i;
    logic        reg_err_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic [1:0]  rsp_err_o;
    logic        rsp_wr_o;
    logic        rsp_ready_i;

    int n_tests = 0;
    int n_fail  = 0;
    bit armed   = 1'b0;

    regmodel0_regmodel_core_reg_intf_reqseq #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_payload_i(req_payload_i), .req_ready_o(req_ready_o),
        .reg_req_o(reg_req_o), .reg_wr_o(reg_wr_o), .reg_addr_o(reg_addr_o),
        .reg_be_o(reg_be_o), .reg_wdata_o(reg_wdata_o),
        .reg_ack_i(reg_ack_i), .reg_rdata_i(reg_rdata_i), .reg_err_i(reg_err_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .rsp_wr_o(rsp_wr_o), .rsp_ready_i(rsp_ready_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Transaction-level reference: one request in flight, then one pending response
    bit          m_inflight = 1'b0;
    bit          m_have_rsp = 1'b0;
    int          m_wait     = 0;
    bit          m_wr       = 1'b0;
    logic [20:0] m_addr     = '0;
    logic [3:0]  m_be       = '0;
    logic [31:0] m_wdata    = '0;
    logic [31:0] m_rdata    = '0;
    logic [1:0]  m_err      = '0;

    always @(posedge clk) begin
        int a;
        if (rst) begin
            m_inflight = 1'b0;
            m_have_rsp = 1'b0;
        end else if (m_have_rsp) begin
            if (rsp_ready_i) m_have_rsp = 1'b0;
        end else if (m_inflight) begin
            m_wait = m_wait + 1;
            if (reg_ack_i) begin
                m_err      = reg_err_i ? 2'd1 : 2'd0;
                m_rdata    = (!m_wr && !reg_err_i) ? reg_rdata_i : 32'd0;
                m_inflight = 1'b0;
                m_have_rsp = 1'b1;
            end else if (m_wait == TO) begin
                m_err      = 2'd2;
                m_rdata    = 32'd0;
                m_inflight = 1'b0;
                m_have_rsp = 1'b1;
            end
        end else if (req_valid_i) begin
            a       = int'(req_payload_i[54:32]);
            m_wr    = req_payload_i[59];
            m_be    = m_wr ? req_payload_i[58:55] : 4'hF;
            m_addr  = 21'(a / 4);
            m_wdata = m_wr ? req_payload_i[31:0] : 32'd0;
            m_rdata = 32'd0;
            if ((a % 4) != 0 || (m_wr && req_payload_i[58:55] == 4'h0)) begin
                m_err      = 2'd3;
                m_have_rsp = 1'b1;
            end else begin
                m_inflight = 1'b1;
                m_wait     = 0;
            end
        end
    end

    // Every-cycle comparison of all outputs against the reference
    always @(posedge clk) begin
        #2;
        if (armed) begin
            chk("req_ready", {63'd0, req_ready_o}, {63'd0, !rst && !m_inflight && !m_have_rsp});
            chk("reg_req",   {63'd0, reg_req_o},   {63'd0, m_inflight});
            chk("reg_wr",    {63'd0, reg_wr_o},    {63'd0, m_inflight && m_wr});
            chk("reg_addr",  {43'd0, reg_addr_o},  {43'd0, m_inflight ? m_addr : 21'd0});
            chk("reg_be",    {60'd0, reg_be_o},    {60'd0, m_inflight ? m_be : 4'd0});
            chk("reg_wdata", {32'd0, reg_wdata_o}, {32'd0, m_inflight ? m_wdata : 32'd0});
            chk("rsp_valid", {63'd0, rsp_valid_o}, {63'd0, m_have_rsp});
            chk("rsp_rdata", {32'd0, rsp_rdata_o}, {32'd0, m_have_rsp ? m_rdata : 32'd0});
            chk("rsp_err",   {62'd0, rsp_err_o},   {62'd0, m_have_rsp ? m_err : 2'd0});
            chk("rsp_wr",    {63'd0, rsp_wr_o},    {63'd0, m_have_rsp && m_wr});
        end
    end

    task automatic send(input logic [59:0] p);
        @(negedge clk);
        req_valid_i   = 1'b1;
        req_payload_i = p;
        @(negedge clk);
        req_valid_i   = 1'b0;
        req_payload_i = 60'd0;
    endtask

    task automatic ack(input logic err, input logic [31:0] rd);
        @(negedge clk);
        reg_ack_i   = 1'b1;
        reg_err_i   = err;
        reg_rdata_i = rd;
        @(negedge clk);
        reg_ack_i   = 1'b0;
        reg_err_i   = 1'b0;
        reg_rdata_i = 32'd0;
    endtask

    task automatic release_rsp();
        @(negedge clk);
        rsp_ready_i = 1'b1;
        @(negedge clk);
        rsp_ready_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int hi;
        rst = 1'b1; req_valid_i = 1'b0; req_payload_i = 60'd0;
        reg_ack_i = 1'b0; reg_rdata_i = 32'd0; reg_err_i = 1'b0; rsp_ready_i = 1'b0;
        @(posedge clk);
        armed = 1'b1;
        idle(2);
        chk("rst_ready_low", {63'd0, req_ready_o}, 64'd0);
        chk("rst_req_low",   {63'd0, reg_req_o},   64'd0);
        chk("rst_rsp_low",   {63'd0, rsp_valid_o}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {63'd0, req_ready_o}, 64'd1);

        // Write OK
        send({1'b1, 4'hF, 23'h000104, 32'hDEADBEEF});
        chk("wr_req",   {63'd0, reg_req_o},   64'd1);
        chk("wr_addr",  {43'd0, reg_addr_o},  64'h41);
        chk("wr_wdata", {32'd0, reg_wdata_o}, 64'hDEADBEEF);
        @(negedge clk);
        ack(1'b0, 32'd0);
        chk("wr_rsp_valid", {63'd0, rsp_valid_o}, 64'd1);
        chk("wr_rsp_err",   {62'd0, rsp_err_o},   64'd0);
        chk("wr_rsp_wr",    {63'd0, rsp_wr_o},    64'd1);
        release_rsp();

        // Read with back-pressure
        send({1'b0, 4'h0, 23'h000010, 32'h0});
        chk("rd_be", {60'd0, reg_be_o}, 64'hF);
        ack(1'b0, 32'h12345678);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {63'd0, rsp_valid_o}, 64'd1);
            chk("bp_rdata", {32'd0, rsp_rdata_o}, 64'h12345678);
            chk("bp_ready", {63'd0, req_ready_o}, 64'd0);
            @(negedge clk);
        end
        rsp_ready_i = 1'b1;
        @(negedge clk);
        rsp_ready_i = 1'b0;
        chk("bp_ready_back", {63'd0, req_ready_o}, 64'd1);

        // Slave error
        send({1'b0, 4'h0, 23'h000020, 32'h0});
        ack(1'b1, 32'hFFFFFFFF);
        chk("slv_err",   {62'd0, rsp_err_o},   64'd1);
        chk("slv_rdata", {32'd0, rsp_rdata_o}, 64'd0);
        release_rsp();

        // Timeout, then a late ack that must be ignored
        send({1'b0, 4'h0, 23'h000030, 32'h0});
        hi = 0;
        for (int i = 0; i < 9; i++) begin
            if (reg_req_o) hi++;
            @(negedge clk);
        end
        chk("to_req_cycles", 64'(hi), 64'd4);
        chk("to_err", {62'd0, rsp_err_o}, 64'd2);
        ack(1'b0, 32'hA5A5A5A5);
        chk("late_ack_err",   {62'd0, rsp_err_o},   64'd2);
        chk("late_ack_rdata", {32'd0, rsp_rdata_o}, 64'd0);
        release_rsp();

        // Ack in the final timeout cycle wins
        send({1'b0, 4'h0, 23'h000040, 32'h0});
        idle(2);
        ack(1'b0, 32'h0BADF00D);
        chk("edge_ack_err",   {62'd0, rsp_err_o},   64'd0);
        chk("edge_ack_rdata", {32'd0, rsp_rdata_o}, 64'h0BADF00D);
        release_rsp();

        // Decode errors
        send({1'b0, 4'h0, 23'h000102, 32'h0});
        chk("dec_addr_valid", {63'd0, rsp_valid_o}, 64'd1);
        chk("dec_addr_err",   {62'd0, rsp_err_o},   64'd3);
        chk("dec_addr_noreq", {63'd0, reg_req_o},   64'd0);
        release_rsp();
        send({1'b1, 4'h0, 23'h000020, 32'h11112222});
        chk("dec_be_err",   {62'd0, rsp_err_o},   64'd3);
        chk("dec_be_rdata", {32'd0, rsp_rdata_o}, 64'd0);
        release_rsp();

        // Reset in ACCESS
        send({1'b0, 4'h0, 23'h000050, 32'h0});
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_req", {63'd0, reg_req_o}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", {63'd0, req_ready_o}, 64'd1);
        idle(3);
        chk("rst_no_rsp", {63'd0, rsp_valid_o}, 64'd0);

        // Back-to-back write after recovery
        send({1'b1, 4'h3, 23'h0007FC, 32'hCAFEF00D});
        chk("wr2_addr", {43'd0, reg_addr_o}, 64'h1FF);
        chk("wr2_be",   {60'd0, reg_be_o},   64'h3);
        ack(1'b0, 32'hFFFF0000);
        chk("wr2_rdata", {32'd0, rsp_rdata_o}, 64'd0);
        release_rsp();
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
